main_feeder: RTL and testbench
==============================

Name: main_feeder

Overview:
- Upstream issue stage for the `main` compute block.
- Buffers operand/mode requests from the host in a small FIFO, then presents them to `main` one at a time on `x`/`on`, pulsing `start`.
- Tracks `main`'s busy flag `b` and captures `y` into a result register with a valid/ready handshake.
- Guarantees `main` never receives `start` while busy, and detects a stalled `main` by timeout.

Parameters:
- W, 8: operand and result width (matches `x`/`y`).
- DEPTH, 4: request FIFO entries; power of two, >=2.
- TIMEOUT, 15: max cycles to wait for `b` to rise after `start`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- wr_valid  in  1  host request valid.
- wr_ready  out  1  FIFO not full.
- wr_data  in  W  operand.
- wr_mode  in  2  regime for this request, 1..3; 0 is illegal.
- x  out  W  operand to `main`.
- on  out  2  mode to `main`.
- start  out  1  one-cycle start pulse to `main`.
- b  in  1  `main` busy.
- y  in  W  `main` result; valid on the cycle `b` falls.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  captured result.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset values: x=0, on=0, start=0, res_valid=0, res_data=0, level=0, err_timeout=0, wr_ready=1, FSM=IDLE.
- FIFO push when wr_valid && wr_ready.
  - A request with wr_mode=0 is accepted (handshake completes) but dropped: not stored, no level change.
- FIFO pop only on the IDLE->LOAD transition.
- Simultaneous push and pop while full is not possible (wr_ready=0). Push and pop in the same cycle at any other level leaves level unchanged.
- Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: go to LOAD when level>0 && !res_valid && !b. Pop the head entry, register x<=data and on<=mode.
  - LOAD: one cycle so x/on are stable before start. Go to FIRE.
  - FIRE: start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - When b=1, go to WAIT_DONE.
    - Otherwise increment the counter. If it reaches TIMEOUT, set err_timeout=1, set on=0, and return to IDLE. The request is discarded.
  - WAIT_DONE: when b=0, set res_data<=y and res_valid<=1, then go to IDLE.
- x and on hold their last values between requests. Only the timeout path zeroes `on`.
- Result handshake:
  - res_valid clears on the cycle after res_valid && res_ready.
  - While res_valid=1 no new request is issued (backpressure). The FIFO still accepts host writes.
- Latency: first push with an empty FIFO and idle `main` -> start high 3 cycles later (push edge, IDLE->LOAD, LOAD->FIRE).
- err_timeout clears only on reset.
- Asserting rst mid-operation:
  - Aborts immediately.
  - Flushes the FIFO (level=0).
  - Drops start the same instant.
  - Clears res_valid.
- start is never asserted while b=1. A bench assertion checks this.

Decomposition:
- Shared package main_pkg:
  - mode_t, a 2-bit enum: OFF=0, M1, M2, M3.
  - feeder_state_t enum: IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE.
  - Default W.
- One sub-module, feeder_fifo: a synchronous FIFO of {mode,data} with push/pop/level/full/empty.
- FSM and result register stay in main_feeder.

Test Plan:
1. Reset: hold rst=0 with wr_valid=1 -> wr_ready=1, level=0, start=0, on=0 throughout; no push recorded after release unless wr_valid is still high.
2. Single request: push data=5, mode=1 into an idle model with 2-cycle busy -> x=5, on=1 stable one cycle before start; one start pulse 3 cycles after push; res_valid=1 with res_data equal to model y (e.g. 13); res_ready=1 clears it the next cycle.
3. Fill: push 5 requests with res_ready=0 -> level reaches 4, wr_ready=0 on the 5th until a pop. Only one result is issued until res_ready, then requests issue in FIFO order 5,13,7,2.
4. Illegal mode: push mode=0 data=9 -> level unchanged, no start issued.
5. Timeout: model never raises b -> err_timeout=1 exactly TIMEOUT=15 cycles after start; on=0; the next queued request still issues.
6. Mid-operation reset: drop rst during WAIT_DONE with level=2 -> all outputs at reset values immediately; after release, no start until a new push.

Source files
------------

// File: rtl/main_pkg.sv
// main_pkg: shared types and defaults for the main compute block issue stage.
package main_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {OFF, M1, M2, M3} mode_t;
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE} feeder_state_t;
endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: synchronous request FIFO with occupancy, full and empty flags.
module feeder_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  assign dout = mem[rptr];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/main_feeder.sv
// main_feeder: queues host requests and issues them one at a time to main,
// capturing each result and flagging a main that never goes busy.
module main_feeder
  import main_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [W-1:0]           wr_data,
  input  logic [1:0]             wr_mode,
  output logic [W-1:0]           x,
  output mode_t                  on,
  output logic                   start,
  input  logic                   b,
  input  logic [W-1:0]           y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_timeout
);
  localparam int CW = $clog2(TIMEOUT+1);
  feeder_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [W+1:0] head;
  logic push, pop, full, empty, go, tmo;
  assign wr_ready = !full;
  assign push = wr_valid && wr_ready && |wr_mode;
  assign go = !empty && !res_valid && !b;
  assign tmo = state == WAIT_BUSY && !b && cnt == CW'(TIMEOUT-1);
  feeder_fifo #(.W(W+2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din({wr_mode, wr_data}),
    .dout(head), .level(level), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = go ? LOAD : IDLE;
      LOAD:      nxt = FIRE;
      FIRE:      nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = b ? WAIT_DONE : tmo ? IDLE : WAIT_BUSY;
      WAIT_DONE: nxt = b ? WAIT_DONE : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    start = state == FIRE;
    pop = state == IDLE && go;
  end
  // cnt counts cycles since start, the start cycle itself included
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x <= '0;
      on <= OFF;
      cnt <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) begin
        x <= head[W-1:0];
        on <= mode_t'(head[W+1:W]);
      end
      if (state == FIRE) cnt <= CW'(1);
      else if (state == WAIT_BUSY && !b) cnt <= cnt + 1'b1;
      if (tmo) begin
        err_timeout <= 1'b1;
        on <= OFF;
      end
      if (state == WAIT_DONE && !b) begin
        res_data <= y;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_main_feeder.sv
// tb_main_feeder: scoreboard bench for main_feeder with a behavioural main model.
module tb_main_feeder;
  localparam int W = 8, DEPTH = 4, TIMEOUT = 15;
  logic clk = 0, rst = 0, wr_valid = 0, b = 0, res_ready = 0, hang = 0;
  logic wr_ready, start, res_valid, err_timeout, prev_start = 0;
  logic [W-1:0] wr_data = 0, y = 0, x, res_data;
  logic [1:0] wr_mode = 0, on;
  logic [$clog2(DEPTH):0] level;
  logic [9:0] iss_q[$];
  logic [7:0] res_q[$];
  logic [9:0] mon_e;
  int n_cmp = 0, n_err = 0, nstart = 0, busy_len = 2, bc = 0, n = 0, s0 = 0;

  main_feeder #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_mode(wr_mode), .x(x), .on(on), .start(start), .b(b), .y(y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .level(level), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [7:0] d, input logic [1:0] m);
    return 8'(d * 2 + 3 * m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // main model: goes busy the cycle after start for busy_len cycles
  always @(posedge clk) begin
    if (start && !hang) begin
      b <= 1'b1;
      bc <= busy_len;
      y <= f(x, on);
    end else if (b) begin
      bc <= bc - 1;
      if (bc <= 1) b <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst && start) begin
      nstart++;
      chk("start_busy", b, 0);
      chk("start_pulse", prev_start, 0);
      if (iss_q.size() == 0) chk("start_unexp", start, 0);
      else begin
        mon_e = iss_q.pop_front();
        chk("x", x, mon_e[7:0]);
        chk("on", on, mon_e[9:8]);
        if (!hang) res_q.push_back(f(mon_e[7:0], mon_e[9:8]));
      end
    end
    if (rst && res_valid && res_ready) begin
      if (res_q.size() == 0) chk("res_unexp", res_valid, 0);
      else chk("res_data", res_data, res_q.pop_front());
    end
    prev_start = start;
  end

  always @(negedge clk)
    if (rst) assert (!(start && b)) else $error("FAIL start_while_busy");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    int k = 0;
    while (!wr_ready && k < 100) begin tick(); k++; end
    chk("push_ready", wr_ready, 1);
    wr_valid = 1; wr_data = d; wr_mode = m;
    if (m != 0) iss_q.push_back({m, d});
    tick();
    wr_valid = 0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!start && k < 200);
    chk("start_seen", start, 1);
  endtask

  task automatic wait_res(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!res_valid && k < 200);
    chk("res_seen", res_valid, 1);
  endtask

  task automatic drain();
    int k = 0;
    do begin @(negedge clk); k++; end
    while ((iss_q.size() != 0 || res_q.size() != 0 || res_valid) && k < 400);
    chk("drain_q", iss_q.size() + res_q.size(), 0);
    chk("drain_res_valid", res_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with a pending write
    wr_valid = 1; wr_data = 3; wr_mode = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", wr_ready, 1);
      chk("rst_level", level, 0);
      chk("rst_start", start, 0);
      chk("rst_on", on, 0);
    end
    chk("rst_x", x, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err_timeout, 0);
    tick();
    wr_valid = 0; rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_level", level, 0);
    chk("post_rst_nstart", nstart, 0);
    // single request
    tick();
    push(5, 1);
    wait_start(n);
    chk("start_latency", n, 3);
    wait_res(n);
    chk("res_latency", n, 4);
    chk("res_value", res_data, 13);
    tick(); res_ready = 1;
    @(negedge clk);
    tick(); res_ready = 0;
    @(negedge clk);
    chk("res_clear", res_valid, 0);
    // fill while a result is held
    tick();
    push(1, 2);
    wait_res(n);
    s0 = nstart;
    tick();
    push(5, 1); push(13, 2); push(7, 3); push(2, 1);
    @(negedge clk);
    chk("fill_level", level, 4);
    chk("fill_ready", wr_ready, 0);
    tick();
    wr_valid = 1; wr_data = 11; wr_mode = 3;
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_ready", wr_ready, 0);
      chk("full_hold_level", level, 4);
    end
    chk("backpressure_nstart", nstart, s0);
    tick(); res_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_ready && n < 100);
    chk("full_release", wr_ready, 1);
    if (wr_ready) iss_q.push_back({2'd3, 8'd11});
    tick(); wr_valid = 0;
    drain();
    chk("fill_drain_level", level, 0);
    // illegal mode is swallowed
    tick();
    s0 = nstart;
    push(9, 0);
    @(negedge clk);
    chk("illegal_level", level, 0);
    repeat (8) @(negedge clk);
    chk("illegal_nostart", nstart, s0);
    // timeout on a main that never goes busy
    tick();
    hang = 1;
    push(20, 2); push(21, 1);
    wait_start(n);
    tick(); hang = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
    chk("tmo_latency", n, 15);
    chk("tmo_on", on, 0);
    chk("tmo_err", err_timeout, 1);
    drain();
    chk("tmo_sticky", err_timeout, 1);
    // reset while main is busy with two requests queued
    busy_len = 20;
    tick();
    push(30, 1);
    wait_start(n);
    tick();
    push(31, 2); push(32, 3);
    @(negedge clk);
    chk("pre_rst_level", level, 2);
    chk("pre_rst_busy", b, 1);
    #2 rst = 0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_on", on, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_ready", wr_ready, 1);
    chk("mid_rst_err", err_timeout, 0);
    iss_q.delete();
    res_q.delete();
    busy_len = 2;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    s0 = nstart;
    repeat (30) @(negedge clk);
    chk("post_rst_nostart", nstart, s0);
    tick();
    push(40, 3);
    drain();
    chk("final_nstart", nstart, s0 + 1);
    chk("final_level", level, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
